// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : acc_pkg
// Brief   : Shared types and default sizes for the accumulator drain engine.
// Rev     : 1.0  initial release
// ============================================================================
package acc_pkg;

    localparam int NO_VECTORS_DEF        = 4096;
    localparam int SELECTOR_WIDTH_DEF    = 12;
    localparam int NO_ACC_PER_VECTOR_DEF = 256;
    localparam int ACC_WIDTH_DEF         = 32;
    localparam int LANES_DEF             = 16;
    localparam int BEATS_PER_VECTOR_DEF  = NO_ACC_PER_VECTOR_DEF / LANES_DEF;

    typedef logic [ACC_WIDTH_DEF-1:0] acc_elem_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_STREAM  = 3'd3,
        ST_FINISH  = 3'd4
    } drain_state_t;

    function automatic int beats_per_vector(input int n_acc, input int lanes);
        return n_acc / lanes;
    endfunction

endpackage : acc_pkg
`default_nettype wire

// File: rtl/accumulator_drain_if.sv
`default_nettype none
// ============================================================================
// Module  : accumulator_drain_if
// Brief   : Valid/ready beat stream from the drain engine to the writeback path.
// Rev     : 1.0  initial release
// ============================================================================
interface accumulator_drain_if
    import acc_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int LANES     = LANES_DEF
);

    logic [ACC_WIDTH-1:0] OUT_DATA [LANES];
    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic                 OUT_VEC_LAST;
    logic                 OUT_LAST;

    modport master (
        output OUT_DATA,
        output OUT_VALID,
        output OUT_VEC_LAST,
        output OUT_LAST,
        input  OUT_READY
    );

    modport slave (
        input  OUT_DATA,
        input  OUT_VALID,
        input  OUT_VEC_LAST,
        input  OUT_LAST,
        output OUT_READY
    );

endinterface : accumulator_drain_if
`default_nettype wire

// File: rtl/accumulator_drain_serializer.sv
`default_nettype none
// ============================================================================
// Module  : vector_beat_serializer
// Brief   : Captures one accumulator vector and emits it as LANES-wide beats.
// Rev     : 1.0  initial release
// ============================================================================
module vector_beat_serializer
    import acc_pkg::*;
#(
    parameter int NO_ACC_PER_VECTOR = NO_ACC_PER_VECTOR_DEF,
    parameter int ACC_WIDTH         = ACC_WIDTH_DEF,
    parameter int LANES             = LANES_DEF
) (
    input  wire                 clk,
    input  wire                 rst,
    input  wire                 i_capture,
    input  wire                 i_stream,
    input  wire                 i_final_vector,
    input  wire [ACC_WIDTH-1:0] i_read_vector [NO_ACC_PER_VECTOR],
    output logic                o_last_hs,
    accumulator_drain_if.master m_if
);

    localparam int c_BEATS  = beats_per_vector(NO_ACC_PER_VECTOR, LANES);
    localparam int c_BEAT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_ELEM_W = (NO_ACC_PER_VECTOR > 1) ? $clog2(NO_ACC_PER_VECTOR) : 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_BEATS - 1);

    logic [ACC_WIDTH-1:0] r_buf [NO_ACC_PER_VECTOR];
    logic [c_BEAT_W-1:0]  r_beat;
    logic                 w_hs;
    logic                 w_vec_last;

    assign w_hs       = i_stream && m_if.OUT_READY;
    assign w_vec_last = (r_beat == c_LAST_BEAT);
    assign o_last_hs  = w_hs && w_vec_last;

    // Capture buffer carries no reset: it is always refilled before streaming.
    always_ff @(posedge clk) begin
        if (i_capture) begin
            r_buf <= i_read_vector;
        end
    end

    // The beat index only moves on a handshake, which holds data during stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= '0;
        end else if (i_capture || o_last_hs) begin
            r_beat <= '0;
        end else if (w_hs) begin
            r_beat <= r_beat + c_BEAT_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            m_if.OUT_DATA[i] = i_stream ? r_buf[c_ELEM_W'(int'(r_beat) * LANES + i)] : '0;
        end
    end

    assign m_if.OUT_VALID    = i_stream;
    assign m_if.OUT_VEC_LAST = i_stream && w_vec_last;
    assign m_if.OUT_LAST     = i_stream && w_vec_last && i_final_vector;

endmodule : vector_beat_serializer
`default_nettype wire

// File: rtl/accumulator_drain.sv
`default_nettype none
// ============================================================================
// Module  : accumulator_drain
// Brief   : Walks a slot range of the accumulator bank and streams each vector out.
// Rev     : 1.0  initial release
// ============================================================================
module accumulator_drain
    import acc_pkg::*;
#(
    parameter int NO_VECTORS        = NO_VECTORS_DEF,
    parameter int SELECTOR_WIDTH    = SELECTOR_WIDTH_DEF,
    parameter int NO_ACC_PER_VECTOR = NO_ACC_PER_VECTOR_DEF,
    parameter int ACC_WIDTH         = ACC_WIDTH_DEF,
    parameter int LANES             = LANES_DEF,
    parameter int READ_LATENCY      = 1
) (
    input  wire                      CLK,
    input  wire                      SYNC_RST,
    input  wire                      START,
    input  wire [SELECTOR_WIDTH-1:0] BASE_VECTOR,
    input  wire [SELECTOR_WIDTH:0]   VECTOR_COUNT,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [SELECTOR_WIDTH-1:0] ReadVectorSelector,
    input  wire [ACC_WIDTH-1:0]      ReadVector [NO_ACC_PER_VECTOR],
    accumulator_drain_if.master      out_if
);

    localparam int c_LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [c_LAT_W-1:0]      c_LAT_LAST = c_LAT_W'(READ_LATENCY - 1);
    localparam logic [SELECTOR_WIDTH:0] c_REM_ONE  = (SELECTOR_WIDTH+1)'(1);

    generate
        if (NO_ACC_PER_VECTOR % LANES != 0) begin : g_bad_lanes
            $error("NO_ACC_PER_VECTOR must be a multiple of LANES");
        end
        if (NO_VECTORS > (1 << SELECTOR_WIDTH)) begin : g_bad_selector
            $error("SELECTOR_WIDTH too narrow for NO_VECTORS");
        end
        if (READ_LATENCY < 1) begin : g_bad_latency
            $error("READ_LATENCY must be at least 1");
        end
    endgenerate

    drain_state_t            r_state;
    drain_state_t            w_next_state;
    logic [SELECTOR_WIDTH:0] r_remaining;
    logic [c_LAT_W-1:0]      r_lat_cnt;
    logic                    w_last_hs;
    logic                    w_capture;
    logic                    w_stream;
    logic                    w_final_vector;
    logic                    w_more_vectors;
    logic                    w_accept;

    assign w_final_vector = (r_remaining == c_REM_ONE);
    assign w_more_vectors = (r_remaining > c_REM_ONE);
    assign w_accept       = (r_state == ST_IDLE) && START && (VECTOR_COUNT != '0);

    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_next_state = (VECTOR_COUNT != '0) ? ST_WAIT : ST_FINISH;
                end
            end
            ST_WAIT: begin
                if (r_lat_cnt == c_LAT_LAST) begin
                    w_next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: w_next_state = ST_STREAM;
            ST_STREAM: begin
                if (w_last_hs) begin
                    w_next_state = w_more_vectors ? ST_WAIT : ST_FINISH;
                end
            end
            ST_FINISH: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY      = 1'b0;
        DONE      = 1'b0;
        w_capture = 1'b0;
        w_stream  = 1'b0;
        case (r_state)
            ST_WAIT:    BUSY = 1'b1;
            ST_CAPTURE: begin
                BUSY      = 1'b1;
                w_capture = 1'b1;
            end
            ST_STREAM: begin
                BUSY     = 1'b1;
                w_stream = 1'b1;
            end
            ST_FINISH:  DONE = 1'b1;
            default:    ;
        endcase
    end

    // The selector only moves between vectors, so the bank output stays put while streaming.
    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            ReadVectorSelector <= '0;
            r_remaining        <= '0;
            r_lat_cnt          <= '0;
        end else begin
            r_lat_cnt <= (r_state == ST_WAIT) ? r_lat_cnt + c_LAT_W'(1) : '0;
            if (w_accept) begin
                ReadVectorSelector <= BASE_VECTOR;
                r_remaining        <= VECTOR_COUNT;
            end else if (w_last_hs && w_more_vectors) begin
                ReadVectorSelector <= ReadVectorSelector + SELECTOR_WIDTH'(1);
                r_remaining        <= r_remaining - c_REM_ONE;
            end
        end
    end

    vector_beat_serializer #(
        .NO_ACC_PER_VECTOR (NO_ACC_PER_VECTOR),
        .ACC_WIDTH         (ACC_WIDTH),
        .LANES             (LANES)
    ) u_serializer (
        .clk            (CLK),
        .rst            (SYNC_RST),
        .i_capture      (w_capture),
        .i_stream       (w_stream),
        .i_final_vector (w_final_vector),
        .i_read_vector  (ReadVector),
        .o_last_hs      (w_last_hs),
        .m_if           (out_if)
    );

endmodule : accumulator_drain
`default_nettype wire

// File: tb/tb_accumulator_drain.sv
`default_nettype none
// ============================================================================
// Module  : tb_accumulator_drain
// Brief   : Self-checking bench for accumulator_drain on a small configuration.
// Rev     : 1.0  initial release
// ============================================================================
module tb_accumulator_drain;
    import acc_pkg::*;

    localparam int SW    = 4;
    localparam int NV    = 16;
    localparam int NACC  = 8;
    localparam int AW    = 32;
    localparam int LN    = 4;
    localparam int RL    = 1;
    localparam int BEATS = NACC / LN;

    typedef struct packed {
        logic [LN*AW-1:0] data;
        logic             vec_last;
        logic             last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [SW-1:0] base;
    logic [SW:0]   count;
    logic          busy;
    logic          done;
    logic [SW-1:0] sel;
    acc_elem_t     rvec [NACC];
    logic [SW-1:0] sel_d;

    always #5 clk = ~clk;

    accumulator_drain_if #(.ACC_WIDTH(AW), .LANES(LN)) out_if ();

    accumulator_drain #(
        .NO_VECTORS(NV), .SELECTOR_WIDTH(SW), .NO_ACC_PER_VECTOR(NACC),
        .ACC_WIDTH(AW), .LANES(LN), .READ_LATENCY(RL)
    ) dut (
        .CLK(clk), .SYNC_RST(rst), .START(start), .BASE_VECTOR(base),
        .VECTOR_COUNT(count), .BUSY(busy), .DONE(done),
        .ReadVectorSelector(sel), .ReadVector(rvec), .out_if(out_if)
    );

    // Accumulator bank model: slot s element j holds s*100+j, one cycle after selection.
    always @(posedge clk) sel_d <= sel;
    always_comb begin
        for (int j = 0; j < NACC; j++) rvec[j] = AW'(int'(sel_d) * 100 + j);
    end

    int    n_checks = 0;
    int    n_pass   = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];
    logic [SW-1:0] exp_sel[$];
    logic [SW-1:0] sel_q[$];
    int    busy_cycles, done_cycle, last_hs_cycle, stall_viol;
    bit    timed_out;

    function automatic void model(input int b, input int n);
        exp_q.delete();
        exp_sel.delete();
        for (int v = 0; v < n; v++) begin
            int s;
            s = (b + v) % NV;
            exp_sel.push_back(SW'(s));
            for (int bt = 0; bt < BEATS; bt++) begin
                beat_t e;
                for (int i = 0; i < LN; i++) e.data[i*AW +: AW] = AW'(s * 100 + bt * LN + i);
                e.vec_last = (bt == BEATS - 1);
                e.last     = (bt == BEATS - 1) && (v == n - 1);
                exp_q.push_back(e);
            end
        end
    endfunction

    // Runs one drain and records what came out; the calling test judges it.
    task automatic drive_drain(input int b, input int n, input int mode, input int inject_at);
        beat_t cur, prev;
        bit    prev_stall, rdy;
        obs_q.delete();
        sel_q.delete();
        busy_cycles = 0; done_cycle = 0; last_hs_cycle = 0; stall_viol = 0;
        timed_out = 0; prev_stall = 0; prev = '0;
        start = 1'b1;
        base  = SW'(b);
        count = (SW+1)'(n);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == inject_at) begin
                start = 1'b1; base = SW'(9); count = (SW+1)'(3);
            end
            for (int i = 0; i < LN; i++) cur.data[i*AW +: AW] = out_if.OUT_DATA[i];
            cur.vec_last = out_if.OUT_VEC_LAST;
            cur.last     = out_if.OUT_LAST;
            if (prev_stall && (!out_if.OUT_VALID || cur !== prev)) stall_viol++;
            if (busy) begin
                busy_cycles++;
                if (sel_q.size() == 0 || sel_q[$] != sel) sel_q.push_back(sel);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 4) == 1) || ((cyc % 4) == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_if.OUT_READY = rdy;
            if (out_if.OUT_VALID && rdy) begin
                obs_q.push_back(cur);
                if (cur.last) last_hs_cycle = cyc;
            end
            prev       = cur;
            prev_stall = out_if.OUT_VALID && !rdy;
            if (done) begin
                done_cycle = cyc;
                break;
            end
        end
        if (done_cycle == 0) timed_out = 1;
    endtask

    task automatic test_reset();
        beat_t cur;
        rst = 1'b1; start = 1'b0; base = '0; count = '0; out_if.OUT_READY = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < LN; i++) cur.data[i*AW +: AW] = out_if.OUT_DATA[i];
        cur.vec_last = out_if.OUT_VEC_LAST;
        cur.last     = out_if.OUT_LAST;
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done got %b want 00", {busy, done});
        else n_pass++;
        n_checks++;
        if (sel !== '0) $display("FAIL reset_selector got %0d want 0", sel);
        else n_pass++;
        n_checks++;
        if (out_if.OUT_VALID !== 1'b0) $display("FAIL reset_valid got %b want 0", out_if.OUT_VALID);
        else n_pass++;
        n_checks++;
        if (cur !== '0) $display("FAIL reset_beat got %h want 0", cur);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        model(2, 2);
        drive_drain(2, 2, 0, 0);
        n_checks++;
        if (timed_out) $display("FAIL basic_timeout got no DONE want DONE");
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL basic_nbeats got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (k >= obs_q.size() || obs_q[k] !== exp_q[k])
                $display("FAIL basic_beat%0d got %h want %h", k, (k < obs_q.size()) ? obs_q[k] : beat_t'(0), exp_q[k]);
            else n_pass++;
        end
        n_checks++;
        if (sel_q.size() != 2 || sel_q[0] !== exp_sel[0] || sel_q[1] !== exp_sel[1])
            $display("FAIL basic_selector got %p want %p", sel_q, exp_sel);
        else n_pass++;
        n_checks++;
        if (busy_cycles != 2 * (BEATS + RL + 1)) $display("FAIL basic_busy_cycles got %0d want %0d", busy_cycles, 2 * (BEATS + RL + 1));
        else n_pass++;
        n_checks++;
        if (done_cycle - last_hs_cycle != 1) $display("FAIL basic_done_delay got %0d want 1", done_cycle - last_hs_cycle);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) $display("FAIL basic_done_width got %b want 0", done);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        model(2, 2);
        drive_drain(2, 2, 1, 0);
        n_checks++;
        if (timed_out) $display("FAIL bp_timeout got no DONE want DONE");
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL bp_nbeats got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (k >= obs_q.size() || obs_q[k] !== exp_q[k])
                $display("FAIL bp_beat%0d got %h want %h", k, (k < obs_q.size()) ? obs_q[k] : beat_t'(0), exp_q[k]);
            else n_pass++;
        end
        n_checks++;
        if (stall_viol != 0) $display("FAIL bp_stall_stable got %0d changes want 0", stall_viol);
        else n_pass++;
        n_checks++;
        if (done_cycle - last_hs_cycle != 1) $display("FAIL bp_done_delay got %0d want 1", done_cycle - last_hs_cycle);
        else n_pass++;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        model(15, 2);
        drive_drain(15, 2, 0, 0);
        n_checks++;
        if (timed_out) $display("FAIL wrap_timeout got no DONE want DONE");
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL wrap_nbeats got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (k >= obs_q.size() || obs_q[k] !== exp_q[k])
                $display("FAIL wrap_beat%0d got %h want %h", k, (k < obs_q.size()) ? obs_q[k] : beat_t'(0), exp_q[k]);
            else n_pass++;
        end
        n_checks++;
        if (sel_q.size() != 2 || sel_q[0] !== 4'd15 || sel_q[1] !== 4'd0)
            $display("FAIL wrap_selector got %p want 15 then 0", sel_q);
        else n_pass++;
    endtask

    task automatic test_zero_count();
        @(negedge clk);
        drive_drain(4, 0, 0, 0);
        n_checks++;
        if (done_cycle != 1) $display("FAIL zero_done_cycle got %0d want 1", done_cycle);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != 0 || busy_cycles != 0)
            $display("FAIL zero_activity got beats=%0d busy=%0d want 0 and 0", obs_q.size(), busy_cycles);
        else n_pass++;
    endtask

    task automatic test_abort();
        bit   seen;
        int   dones;
        beat_t cur;
        @(negedge clk);
        start = 1'b1; base = SW'(3); count = (SW+1)'(2); out_if.OUT_READY = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_if.OUT_VALID) seen = 1;
        end
        n_checks++;
        if (!seen) $display("FAIL abort_reach_stream got no OUT_VALID want OUT_VALID");
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < LN; i++) cur.data[i*AW +: AW] = out_if.OUT_DATA[i];
        cur.vec_last = out_if.OUT_VEC_LAST;
        cur.last     = out_if.OUT_LAST;
        n_checks++;
        if ({busy, done, sel} !== '0) $display("FAIL abort_ctrl got busy=%b done=%b sel=%0d want 0", busy, done, sel);
        else n_pass++;
        n_checks++;
        if (out_if.OUT_VALID !== 1'b0 || cur !== '0) $display("FAIL abort_stream got valid=%b beat=%h want 0", out_if.OUT_VALID, cur);
        else n_pass++;
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        n_checks++;
        if (dones != 0) $display("FAIL abort_no_done got %0d active cycles want 0", dones);
        else n_pass++;
        model(5, 1);
        drive_drain(5, 1, 2, 0);
        n_checks++;
        if (obs_q.size() != exp_q.size() || timed_out) $display("FAIL abort_redrain_nbeats got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (k >= obs_q.size() || obs_q[k] !== exp_q[k])
                $display("FAIL abort_beat%0d got %h want %h", k, (k < obs_q.size()) ? obs_q[k] : beat_t'(0), exp_q[k]);
            else n_pass++;
        end
    endtask

    task automatic test_start_while_busy();
        @(negedge clk);
        model(2, 2);
        drive_drain(2, 2, 0, 3);
        n_checks++;
        if (obs_q.size() != exp_q.size() || timed_out) $display("FAIL busy_start_nbeats got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (k >= obs_q.size() || obs_q[k] !== exp_q[k])
                $display("FAIL busy_start_beat%0d got %h want %h", k, (k < obs_q.size()) ? obs_q[k] : beat_t'(0), exp_q[k]);
            else n_pass++;
        end
        // This START lands in the FINISH cycle and must not be taken.
        start = 1'b1; base = SW'(9); count = (SW+1)'(1);
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL finish_start_ignored got busy=%b want 0", busy);
        else n_pass++;
        model(7, 1);
        drive_drain(7, 1, 0, 0);
        n_checks++;
        if (done_cycle != BEATS + RL + 2) $display("FAIL idle_start_accept got done at %0d want %0d", done_cycle, BEATS + RL + 2);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size() || (obs_q.size() > 0 && obs_q[0] !== exp_q[0]))
            $display("FAIL idle_start_data got %0d beats want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        int b, n, mode;
        for (int t = 0; t < 8; t++) begin
            b    = $urandom_range(0, NV - 1);
            n    = $urandom_range(0, 4);
            mode = $urandom_range(0, 2);
            @(negedge clk);
            model(b, n);
            drive_drain(b, n, mode, 0);
            n_checks++;
            if (timed_out || obs_q.size() != exp_q.size())
                $display("FAIL rand%0d_nbeats got %0d want %0d (base %0d count %0d)", t, obs_q.size(), exp_q.size(), b, n);
            else n_pass++;
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if (k >= obs_q.size() || obs_q[k] !== exp_q[k])
                    $display("FAIL rand%0d_beat%0d got %h want %h", t, k, (k < obs_q.size()) ? obs_q[k] : beat_t'(0), exp_q[k]);
                else n_pass++;
            end
            if (mode == 0) begin
                n_checks++;
                if (busy_cycles != n * (BEATS + RL + 1))
                    $display("FAIL rand%0d_busy got %0d want %0d", t, busy_cycles, n * (BEATS + RL + 1));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_abort();
        test_start_while_busy();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_accumulator_drain
`default_nettype wire
